store_buffer_unit: RTL
======================

// Module: store_buffer_unit
// PURPOSE
//  Store-side counterpart of the writeback load-extraction path. Accepts store ops from the MEM
//  stage, lane-aligns store data and builds byte selects, queues them in a DEPTH-entry FIFO and
//  drains them one at a time over the sram-like data bus (req / addr_ok / data_ok). Flags load
//  address conflicts so the pipeline can stall loads that hit a pending store.
// PARAMETERS
//  DEPTH      4   store FIFO entries (power of two, >=2)
//  PTR_W      2   log2(DEPTH)
// PORTS
//  cpu_clk       in   1   single clock
//  cpu_rst       in   1   reset; asynchronous, active-high
//  st_valid      in   1   store op presented this cycle
//  st_addr       in   32  store byte address
//  st_data       in   32  raw rt register value
//  st_size       in   2   00 byte, 01 half, 10 word (11 treated as word)
//  st_ready      out  1   FIFO can accept (count < DEPTH)
//  st_ade        out  1   1-cycle pulse: misaligned store, op dropped
//  ld_addr       in   32  address of load in MEM stage
//  ld_hit        out  1   comb: any valid entry has ld_addr[31:2] == entry addr[31:2]
//  sb_empty      out  1   FIFO empty and FSM IDLE
//  data_req      out  1   bus request
//  data_wr       out  1   always 1 while data_req
//  data_size     out  2   entry size
//  data_addr     out  32  entry byte address
//  data_wstrb    out  4   bit0 = wdata[7:0]
//  data_wdata    out  32  lane-replicated data
//  data_addr_ok  in   1   slave accepted address/data
//  data_data_ok  in   1   slave completed write
// BEHAVIOUR
//  Reset (async, cpu_rst=1): FIFO count/pointers 0, FSM IDLE; data_req, data_wr, st_ade = 0;
//   data_size, data_addr, data_wstrb, data_wdata = 0; st_ready = 1; sb_empty = 1. Assertion mid-
//   transaction drops data_req immediately and discards all entries.
//  Format (comb, at enqueue): internal bsel bit3 = lane [7:0] ... bit0 = lane [31:24].
//   byte: off 00->1000, 01->0100, 10->0010, 11->0001; wdata = {4{st_data[7:0]}}.
//   half: a[1]=0 ->1100, a[1]=1 ->0011; wdata = {2{st_data[15:0]}}. word: 1111, wdata = st_data.
//   data_wstrb = bit-reverse(bsel); bsel is stored in the entry.
//  Alignment: half with a[0]=1, or word with a[1:0]!=0 -> st_ade=1 next cycle, no enqueue.
//  Enqueue: st_valid & st_ready & aligned, at posedge. st_ready depends only on registered count
//   (no same-cycle pop credit): a push while full is ignored and the MEM stage must hold.
//  FSM: IDLE -> REQ when count>0 (earliest cycle after enqueue). REQ: data_req=1, head fields
//   driven and stable until data_addr_ok; on addr_ok -> WAIT. WAIT: data_req=0; on data_data_ok
//   pop head; -> REQ if count>1, else IDLE. data_data_ok is ignored outside WAIT.
//  Simultaneous push and pop: both occur, count unchanged; pointers wrap modulo DEPTH.
//  ld_hit covers all valid entries including the in-flight head until its data_ok.
//  Strictly one outstanding write; FIFO order preserved.
// TESTING
//  1. sb byte at 0x1000_0003, st_data=0x1234_56AB -> wdata 0xABAB_ABAB, wstrb 1000, size 00,
//     data_req next cycle.
//  2. sh at 0x2002, data 0x0000_BEEF -> wdata 0xBEEF_BEEF, wstrb 1100; sh at 0x2001 -> st_ade
//     pulse, sb_empty stays 1.
//  3. Push 4 words back-to-back, addr_ok delayed 3 cycles -> st_ready=0 after 4th; 5th held;
//     drains in order with req stable.
//  4. Pop (data_ok) and push same cycle at count=2 -> count stays 2; wrap after 6 ops, order kept.
//  5. Pending sw 0x3004; ld_addr 0x3006 -> ld_hit=1; ld_addr 0x3008 -> 0; hit clears after data_ok.
//  6. cpu_rst asserted while in REQ with 3 entries -> data_req=0 same cycle, sb_empty=1,
//     st_ready=1.

Source files
------------

// File: rtl/store_buffer_unit.sv
// Store buffer: lane-aligns MEM-stage stores, queues them in a FIFO and
// drains them one at a time over the req/addr_ok/data_ok data bus.
module store_buffer_unit #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_size,
    output logic        st_ready,
    output logic        st_ade,
    input  logic [31:0] ld_addr,
    output logic        ld_hit,
    output logic        sb_empty,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok
);

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  bsel;
        logic [31:0] wdata;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W + 1)'(1);

    entry_t           mem [DEPTH];
    entry_t           fmt;
    entry_t           nxt;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    state_t           state;
    logic             misaligned;
    logic             push;
    logic             pop;
    logic             unused_ld_low;

    assign unused_ld_low = ^ld_addr[1:0];

    // Lane-align incoming store data and build the byte-select mask.
    always_comb begin
        fmt      = '0;
        fmt.addr = st_addr;
        fmt.size = st_size;
        case (st_size)
            2'b00: begin
                fmt.bsel  = 4'b1000 >> st_addr[1:0];
                fmt.wdata = {4{st_data[7:0]}};
            end
            2'b01: begin
                fmt.bsel  = st_addr[1] ? 4'b0011 : 4'b1100;
                fmt.wdata = {2{st_data[15:0]}};
            end
            default: begin
                fmt.bsel  = 4'b1111;
                fmt.wdata = st_data;
            end
        endcase
        misaligned = ((st_size == 2'b01) && st_addr[0]) ||
                     (st_size[1] && (st_addr[1:0] != 2'b00));
    end

    assign st_ready = (count < CNT_FULL);
    assign push     = st_valid && st_ready && !misaligned;
    assign pop      = (state == S_WAIT) && data_data_ok;
    assign sb_empty = (count == '0) && (state == S_IDLE);

    // When leaving WAIT the head is being popped, so the next bus op is head+1.
    assign nxt = (state == S_WAIT) ? mem[head + PTR_W'(1)] : mem[head];

    // Word-granular conflict check against every queued entry, including
    // the in-flight head until its write completes.
    always_comb begin
        logic [PTR_W-1:0] idx;
        ld_hit = 1'b0;
        idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (((PTR_W + 1)'(i) < count) &&
                (mem[idx].addr[31:2] == ld_addr[31:2]))
                ld_hit = 1'b1;
        end
    end

    // FIFO storage write; validity is tracked by count, so no reset needed.
    always_ff @(posedge cpu_clk) begin
        if (push)
            mem[tail] <= fmt;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push)
                tail <= tail + PTR_W'(1);
            if (pop)
                head <= head + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_ONE;
            else if (!push && pop)
                count <= count - CNT_ONE;
        end
    end

    // One-cycle address-error pulse for a dropped misaligned store.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst)
            st_ade <= 1'b0;
        else
            st_ade <= st_valid && misaligned;
    end

    // Bus FSM with registered outputs; one outstanding write at a time.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state      <= S_IDLE;
            data_req   <= 1'b0;
            data_wr    <= 1'b0;
            data_size  <= '0;
            data_addr  <= '0;
            data_wstrb <= '0;
            data_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (count != '0) begin
                        state      <= S_REQ;
                        data_req   <= 1'b1;
                        data_wr    <= 1'b1;
                        data_size  <= nxt.size;
                        data_addr  <= nxt.addr;
                        data_wstrb <= {nxt.bsel[0], nxt.bsel[1],
                                       nxt.bsel[2], nxt.bsel[3]};
                        data_wdata <= nxt.wdata;
                    end
                end
                S_REQ: begin
                    if (data_addr_ok) begin
                        state    <= S_WAIT;
                        data_req <= 1'b0;
                        data_wr  <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (data_data_ok) begin
                        if (count > CNT_ONE) begin
                            state      <= S_REQ;
                            data_req   <= 1'b1;
                            data_wr    <= 1'b1;
                            data_size  <= nxt.size;
                            data_addr  <= nxt.addr;
                            data_wstrb <= {nxt.bsel[0], nxt.bsel[1],
                                           nxt.bsel[2], nxt.bsel[3]};
                            data_wdata <= nxt.wdata;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    data_req <= 1'b0;
                    data_wr  <= 1'b0;
                end
            endcase
        end
    end

endmodule
